// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared state type, window geometry and tap offsets for the convolution sequencer
package conv_seq_pkg;
  localparam int WIN_TAPS = 9;
  localparam int PIX_W = 8;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, WAIT_RES, WRITE, BORDER, DONE} state_t;
  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } tap_off_t;
  // offsets are two's complement: 2'b11=-1, 2'b00=0, 2'b01=+1
  function automatic tap_off_t tap_off(input logic [3:0] k);
    tap_off_t t;
    t.dy = k < 4'd3 ? 2'b11 : k < 4'd6 ? 2'b00 : 2'b01;
    t.dx = (k == 4'd0 || k == 4'd3 || k == 4'd6) ? 2'b11 :
           (k == 4'd1 || k == 4'd4 || k == 4'd7) ? 2'b00 : 2'b01;
    return t;
  endfunction
endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: frame-buffer and datapath bus between conv_sequencer and its neighbours
interface conv_sequencer_if
  import conv_seq_pkg::*;
#(parameter int ADDR_W = 8);
  logic                      src_rd_en;
  logic [ADDR_W-1:0]         src_addr;
  logic [PIX_W-1:0]          src_rd_data;
  logic                      win_valid;
  logic                      win_ready;
  logic [WIN_TAPS*PIX_W-1:0] win_pixels;
  logic                      res_valid;
  logic [PIX_W-1:0]          res_pixel;
  logic                      dst_wr_en;
  logic [ADDR_W-1:0]         dst_addr;
  logic [PIX_W-1:0]          dst_wr_data;
  modport master (
    output src_rd_en, src_addr, win_valid, win_pixels, dst_wr_en, dst_addr, dst_wr_data,
    input  src_rd_data, win_ready, res_valid, res_pixel
  );
  modport slave (
    input  src_rd_en, src_addr, win_valid, win_pixels, dst_wr_en, dst_addr, dst_wr_data,
    output src_rd_data, win_ready, res_valid, res_pixel
  );
endinterface

// File: rtl/conv_window_pack.sv
// conv_window_pack: 9-tap capture register indexed by k that presents the packed 3x3 window
module conv_window_pack
  import conv_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cap_en,
  input  logic [3:0]                cap_k,
  input  logic [PIX_W-1:0]          cap_data,
  output logic [WIN_TAPS*PIX_W-1:0] win_pixels
);
  logic [WIN_TAPS-1:0][PIX_W-1:0] taps;
  always_ff @(posedge clk or negedge reset)
    if (!reset) taps <= '0;
    else if (cap_en) taps[cap_k] <= cap_data;
  assign win_pixels = taps;
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: 3x3 convolution frame controller; CONV_SEQ_BORDER_REPLICATE_EN clamps border windows instead of writing 0
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op_sel,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic begin_gauss,
  output logic begin_sobel,
  conv_sequencer_if.master bus
);
  localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] YMAX = ADDR_W'(IMG_H - 1);
`ifdef CONV_SEQ_BORDER_REPLICATE_EN
  localparam state_t START_ST = FETCH;
`else
  localparam state_t START_ST = BORDER;
`endif
  state_t state, state_n, adv_st;
  logic [ADDR_W-1:0] x, y, x_adv, y_adv, nx, ny, dxe, dye;
  logic [3:0] k, cap_k;
  logic [PIX_W-1:0] res;
  logic op, go, adv, last, cap_en;
  tap_off_t off;
  assign off = tap_off(k);
  assign dxe = {{(ADDR_W-2){off.dx[1]}}, off.dx};
  assign dye = {{(ADDR_W-2){off.dy[1]}}, off.dy};
`ifdef CONV_SEQ_BORDER_REPLICATE_EN
  assign nx = (x == '0 && off.dx == 2'b11) || (x == XMAX && off.dx == 2'b01) ? x : x + dxe;
  assign ny = (y == '0 && off.dy == 2'b11) || (y == YMAX && off.dy == 2'b01) ? y : y + dye;
  assign adv_st = FETCH;
`else
  assign nx = x + dxe;
  assign ny = y + dye;
  assign adv_st = x_adv != '0 && x_adv != XMAX && y_adv != '0 && y_adv != YMAX ? FETCH : BORDER;
`endif
  assign x_adv = x == XMAX ? '0 : x + ADDR_W'(1);
  assign y_adv = x == XMAX ? y + ADDR_W'(1) : y;
  assign last = x == XMAX && y == YMAX;
  assign go = state == IDLE && start && !abort;
  assign adv = state == WRITE || state == BORDER;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:          if (start) state_n = START_ST;
      FETCH:         if (k == 4'd8) state_n = CAPTURE;
      CAPTURE:       state_n = ISSUE;
      ISSUE:         if (bus.win_ready) state_n = WAIT_RES;
      WAIT_RES:      if (bus.res_valid) state_n = WRITE;
      WRITE, BORDER: state_n = last ? DONE : adv_st;
      DONE:          state_n = IDLE;
      default:       state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      op    <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_n;
      k     <= state == FETCH ? k + 4'd1 : '0;
      if (go) begin
        x  <= '0;
        y  <= '0;
        op <= op_sel;
      end else if (adv && !last) begin
        x <= x_adv;
        y <= y_adv;
      end
      if (state == WAIT_RES && bus.res_valid) res <= bus.res_pixel;
    end
  // read data lags the strobe by one cycle, so FETCH tap k stores the data of tap k-1
  assign cap_en = (state == FETCH && k != '0) || state == CAPTURE;
  assign cap_k  = state == CAPTURE ? 4'd8 : k - 4'd1;
  conv_window_pack u_pack (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .cap_k     (cap_k),
    .cap_data  (bus.src_rd_data),
    .win_pixels(bus.win_pixels)
  );
  assign busy            = state != IDLE;
  assign done            = state == DONE && !abort;
  assign begin_gauss     = busy && !op;
  assign begin_sobel     = busy && op;
  assign bus.src_rd_en   = state == FETCH && !abort;
  assign bus.src_addr    = bus.src_rd_en ? ny * W_A + nx : '0;
  assign bus.win_valid   = state == ISSUE;
  assign bus.dst_wr_en   = adv && !abort;
  assign bus.dst_addr    = bus.dst_wr_en ? y * W_A + x : '0;
  assign bus.dst_wr_data = state == WRITE ? res : '0;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: 4x4 frame bench with a raster-order reference model and a centre-tap datapath
module tb_conv_sequencer;
  localparam int W = 4, H = 4, AW = 8, L = 2;
`ifdef CONV_SEQ_BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 0, reset = 0, start = 0, op_sel = 0, abort = 0;
  logic busy, done, begin_gauss, begin_sobel;
  conv_sequencer_if #(.ADDR_W(AW)) bus();
  conv_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .abort(abort),
    .busy(busy), .done(done), .begin_gauss(begin_gauss), .begin_sobel(begin_sobel), .bus(bus)
  );
  always #5 clk = ~clk;

  int cyc = 0, n_chk = 0, n_pass = 0;
  int n_hs = 0, n_done = 0, n_wr = 0, hs_cyc = -100, done_due = -1, wr_left = 0;
  int start_cyc = 0, done_cyc = 0, stall_n = 0, stall_seen = 0, spur_n = 0;
  logic st_req = 0, st_op = 0, ab_req = 0, m_busy = 0, m_op = 0, rd_pend = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0] hs_val = '0;
  logic [71:0] first_win = '0;
  logic [AW-1:0] rq[$];
  logic [71:0] wq[$];
  logic [15:0] wrq[$];
  logic [7:0] dmem [W*H];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // expected reads, windows and writes of one frame, straight from raster order and tap geometry
  task automatic build();
    rq.delete(); wq.delete(); wrq.delete();
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++) begin
        int a;
        logic [71:0] w;
        a = py * W + px;
        w = '0;
        if (REP || (px > 0 && px < W - 1 && py > 0 && py < H - 1)) begin
          for (int t = 0; t < 9; t++) begin
            int cx, cy;
            cx = px + t % 3 - 1;
            cy = py + t / 3 - 1;
            cx = cx < 0 ? 0 : cx > W - 1 ? W - 1 : cx;
            cy = cy < 0 ? 0 : cy > H - 1 ? H - 1 : cy;
            rq.push_back(AW'(cy * W + cx));
            w[8*t +: 8] = 8'(cy * W + cx);
          end
          wq.push_back(w);
          wrq.push_back({8'(a), 8'(a)});
        end else wrq.push_back({8'(a), 8'h00});
      end
    wr_left = W * H;
    done_due = -1;
  endtask

  task automatic check_cycle();
    logic [15:0] e;
    chk("busy", busy, m_busy);
    chk("done", done, cyc == done_due && !abort);
    chk("begin_gauss", begin_gauss, m_busy && !m_op);
    chk("begin_sobel", begin_sobel, m_busy && m_op);
    if (bus.win_valid) begin
      chk("rd_in_issue", bus.src_rd_en, 1'b0);
      chk("win_expected", wq.size() != 0, 1'b1);
      if (wq.size() != 0) chk("win_pixels", bus.win_pixels, wq[0]);
      if (bus.win_ready) begin
        if (n_hs == 0) first_win = bus.win_pixels;
        n_hs++;
        hs_cyc = cyc;
        hs_val = bus.win_pixels[39:32];
        if (wq.size() != 0) void'(wq.pop_front());
      end
    end
    rd_pend = bus.src_rd_en;
    rd_addr = bus.src_addr;
    if (bus.src_rd_en) begin
      chk("rd_expected", rq.size() != 0, 1'b1);
      if (rq.size() != 0) chk("src_addr", bus.src_addr, rq.pop_front());
    end
    if (bus.dst_wr_en) begin
      chk("wr_expected", wrq.size() != 0, 1'b1);
      if (wrq.size() != 0) begin
        e = wrq.pop_front();
        chk("dst_addr", bus.dst_addr, e[15:8]);
        chk("dst_wr_data", bus.dst_wr_data, e[7:0]);
      end
      dmem[bus.dst_addr[3:0]] = bus.dst_wr_data;
      n_wr++;
      wr_left--;
      if (wr_left == 0) done_due = cyc + 1;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (m_busy && abort) begin
      m_busy = 0;
      rq.delete(); wq.delete(); wrq.delete();
      done_due = -1;
    end else if (m_busy && cyc == done_due) m_busy = 0;
    else if (!m_busy && start && !abort) begin
      m_busy = 1;
      m_op = op_sel;
      start_cyc = cyc;
      build();
    end
  endtask

  // drive inputs just after the edge, check outputs at the falling edge
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    start = st_req; op_sel = st_op; abort = ab_req;
    st_req = 0; ab_req = 0;
    bus.src_rd_data = rd_pend ? rd_addr : 8'hA5;
    if (cyc == hs_cyc + L) begin
      bus.res_valid = 1; bus.res_pixel = hs_val;
    end else if (spur_n > 0 && bus.src_rd_en) begin
      bus.res_valid = 1; bus.res_pixel = 8'hEE; spur_n--;
    end else begin
      bus.res_valid = 0; bus.res_pixel = 8'h00;
    end
    bus.win_ready = !(bus.win_valid && stall_n > 0);
    if (!bus.win_ready) begin
      stall_n--; stall_seen++;
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_done(input string nm);
    int n0;
    n0 = n_done;
    for (int i = 0; i < 2000 && n_done == n0; i++) cycle();
    chk(nm, n_done - n0, 1);
  endtask

  initial begin
    int tgt, nw, nd;
    bus.src_rd_data = 0; bus.win_ready = 1; bus.res_valid = 0; bus.res_pixel = 0;
    foreach (dmem[i]) dmem[i] = 8'hFF;
    repeat (3) cycle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_win_pixels", bus.win_pixels, 72'h0);
    chk("rst_src_addr", bus.src_addr, 8'h0);
    chk("rst_dst_addr", bus.dst_addr, 8'h0);
    reset = 1;
    cycle();

    st_req = 1; st_op = 0;
    wait_done("frameA_done");
    chk("frameA_cycles", done_cyc - start_cyc, REP ? 225 : 69);
    chk("frameA_first_win", first_win, REP ? {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0}
                                           : {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
    chk("frameA_dst5", dmem[5], 8'd5);
    chk("frameA_dst10", dmem[10], 8'd10);
    chk("frameA_dst0", dmem[0], 8'd0);
    chk("frameA_dst15", dmem[15], REP ? 8'd15 : 8'd0);
    repeat (4) cycle();
    chk("frameA_done_once", n_done, 1);
    chk("frameA_drained", rq.size() + wq.size() + wrq.size(), 0);

    stall_seen = 0; stall_n = 5;
    st_req = 1; st_op = 0;
    repeat (20) cycle();
    st_req = 1; st_op = 1;
    nd = n_done;
    wait_done("frameB_done");
    chk("frameB_stall_cycles", stall_seen, 5);
    chk("frameB_gauss_kept", m_op, 1'b0);
    repeat (3) cycle();
    chk("frameB_sobel_idle", begin_sobel, 1'b0);

    foreach (dmem[i]) dmem[i] = 8'hFF;
    spur_n = 1;
    st_req = 1; st_op = 1;
    repeat (5) cycle();
    chk("frameC_sobel_on", begin_sobel, 1'b1);
    wait_done("frameC_done");
    chk("frameC_spur_used", spur_n, 0);
    chk("frameC_dst5", dmem[5], 8'd5);
    chk("frameC_dst6", dmem[6], 8'd6);

    st_req = 1; st_op = 0;
    tgt = n_hs + (REP ? 6 : 1);
    for (int i = 0; i < 2000 && n_hs < tgt; i++) cycle();
    chk("abort_reach_11", n_hs, tgt);
    nw = n_wr; nd = n_done;
    ab_req = 1;
    cycle();
    repeat (10) cycle();
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_write", n_wr, nw);
    chk("abort_no_done", n_done, nd);
    st_req = 1; st_op = 0;
    wait_done("frameE_done");

    st_req = 1; ab_req = 1;
    cycle();
    repeat (3) cycle();
    chk("start_abort_idle", busy, 1'b0);

    st_req = 1; st_op = 1;
    repeat (30) cycle();
    reset = 0;
    #1;
    chk("areset_busy", busy, 1'b0);
    chk("areset_rd", bus.src_rd_en, 1'b0);
    chk("areset_wr", bus.dst_wr_en, 1'b0);
    chk("areset_win", bus.win_pixels, 72'h0);
    chk("areset_sobel", begin_sobel, 1'b0);
    m_busy = 0; rq.delete(); wq.delete(); wrq.delete(); done_due = -1;
    repeat (2) cycle();
    reset = 1;
    cycle();
    st_req = 1; st_op = 0;
    wait_done("frameF_done");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
